mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 42 ++++
 rtl/mem_data_align.sv | 44 ++++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: memory command encodings,
// access-size encodings, FSM state codes and small decode helpers.
package mem_arbiter_pkg;

    // Command presented to the memory on mem_stage_state.
    typedef enum logic [1:0] {
        MEM_IDLE  = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10
    } mem_cmd_e;

    // Arbiter FSM state codes.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_WR_ISSUE = 3'd3,
        ST_DONE     = 3'd4
    } arb_state_e;

    // d_size[1:0] encodings; d_size[2] selects zero-extension of loads.
    localparam logic [1:0] SIZE_BYTE     = 2'b00;
    localparam logic [1:0] SIZE_HALF     = 2'b01;
    localparam logic [1:0] SIZE_WORD     = 2'b10;
    localparam logic [1:0] SIZE_WORD_ALT = 2'b11;
    localparam int         SIZE_ZEXT_BIT = 2;

    // Byte and half accesses are the ones that need extract/merge work.
    function automatic logic is_subword(input logic [1:0] size);
        return (size == SIZE_BYTE) || (size == SIZE_HALF);
    endfunction

    // Memory command implied by being in a given FSM state.
    function automatic mem_cmd_e cmd_for_state(input arb_state_e st);
        case (st)
            ST_RD_ISSUE: return MEM_READ;
            ST_WR_ISSUE: return MEM_WRITE;
            default:     return MEM_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/mem_data_align.sv
// Load extract/extend and store merge for the memory arbiter.
//   size_i    : latched access size (bit 2 = zero-extend loads)
//   rd_word_i : word returned by memory, byte addr in [7:0]
//   wdata_i   : latched store data, low byte/half used for sub-word stores
//   load_o    : extracted and extended load result
//   merge_o   : word to write back (read word with low byte/half replaced)
module mem_data_align
    import mem_arbiter_pkg::*;
#(
    parameter int LEN = 32
)
(
    input  logic [2:0]     size_i,
    input  logic [LEN-1:0] rd_word_i,
    input  logic [LEN-1:0] wdata_i,
    output logic [LEN-1:0] load_o,
    output logic [LEN-1:0] merge_o
);

    logic fill_b;
    logic fill_h;

    always_comb begin
        load_o  = rd_word_i;
        merge_o = wdata_i;
        fill_b  = ~size_i[SIZE_ZEXT_BIT] & rd_word_i[7];
        fill_h  = ~size_i[SIZE_ZEXT_BIT] & rd_word_i[15];
        case (size_i[1:0])
            SIZE_BYTE: begin
                load_o  = {{(LEN-8){fill_b}}, rd_word_i[7:0]};
                merge_o = {rd_word_i[LEN-1:8], wdata_i[7:0]};
            end
            SIZE_HALF: begin
                load_o  = {{(LEN-16){fill_h}}, rd_word_i[15:0]};
                merge_o = {rd_word_i[LEN-1:16], wdata_i[15:0]};
            end
            default: begin
                load_o  = rd_word_i;
                merge_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory port between instruction fetch and
// data load/store. Sub-word stores are done as read-modify-write.
//   clk, rst          : clock, synchronous active-high reset
//   if_req/if_addr    : fetch request (held until if_done), byte address
//   if_done           : one-cycle fetch completion, rdata valid
//   d_req/d_we/d_size : data request, 1=store, size (bit 2 = zero-extend)
//   d_addr/d_wdata    : data byte address, store data
//   d_done            : one-cycle data completion
//   rdata             : last read result, held between reads
//   mem_addr/mem_wdata/mem_stage_state : registered memory command
//   mem_read          : memory word, valid the cycle after a READ
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int LEN        = 32
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [2:0]            d_size,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LEN-1:0]        d_wdata,
    output logic                  d_done,
    output logic [LEN-1:0]        rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LEN-1:0]        mem_wdata,
    output logic [1:0]            mem_stage_state,
    input  logic [LEN-1:0]        mem_read
);

    arb_state_e            state_q;
    arb_state_e            state_d;
    mem_cmd_e              mem_cmd_q;
    // Owner of the current/most recent grant (1 = data); doubles as the
    // "last grant" memory used for arbitration.
    logic                  gnt_data_q;
    logic                  we_q;
    logic [2:0]            size_q;
    logic [LEN-1:0]        wdata_q;
    logic [LEN-1:0]        mem_wdata_q;
    logic [LEN-1:0]        rdata_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  if_done_q;
    logic                  d_done_q;

    logic                  start;
    logic                  pick_data;
    logic [LEN-1:0]        load_word;
    logic [LEN-1:0]        merge_word;

    mem_data_align #(.LEN(LEN)) u_align (
        .size_i    (size_q),
        .rd_word_i (mem_read),
        .wdata_i   (wdata_q),
        .load_o    (load_word),
        .merge_o   (merge_word)
    );

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        pick_data = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    start = 1'b1;
                    // Data wins a tie unless it also won the previous grant.
                    pick_data = d_req && (!if_req || !gnt_data_q);
                    if (pick_data && d_we && !is_subword(d_size[1:0])) begin
                        state_d = ST_WR_ISSUE;
                    end else begin
                        state_d = ST_RD_ISSUE;
                    end
                end
            end
            ST_RD_ISSUE: state_d = ST_RD_WAIT;
            // A store reaching RD_WAIT is a sub-word read-modify-write.
            ST_RD_WAIT:  state_d = we_q ? ST_WR_ISSUE : ST_DONE;
            ST_WR_ISSUE: state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_cmd_q   <= MEM_IDLE;
            gnt_data_q  <= 1'b0;
            we_q        <= 1'b0;
            size_q      <= '0;
            wdata_q     <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            // Memory-side outputs are registered from the next state so the
            // command lines up with the issue states themselves.
            mem_cmd_q <= cmd_for_state(state_d);
            if_done_q <= (state_d == ST_DONE) && !gnt_data_q;
            d_done_q  <= (state_d == ST_DONE) && gnt_data_q;

            if (start) begin
                gnt_data_q <= pick_data;
                we_q       <= pick_data && d_we;
                mem_addr_q <= pick_data ? d_addr : if_addr;
                size_q     <= pick_data ? d_size : {1'b0, SIZE_WORD};
                if (pick_data) begin
                    wdata_q <= d_wdata;
                end
                if (pick_data && d_we) begin
                    mem_wdata_q <= d_wdata;
                end
            end

            if (state_q == ST_RD_WAIT) begin
                if (we_q) begin
                    mem_wdata_q <= merge_word;
                end else begin
                    rdata_q <= load_word;
                end
            end
        end
    end

    assign if_done         = if_done_q;
    assign d_done          = d_done_q;
    assign rdata           = rdata_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_stage_state = mem_cmd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AW   = 17;
    localparam int MASK = (1 << AW) - 1;
    localparam logic [1:0] C_IDLE  = 2'b00;
    localparam logic [1:0] C_READ  = 2'b01;
    localparam logic [1:0] C_WRITE = 2'b10;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_done;
    logic          d_req;
    logic          d_we;
    logic [2:0]    d_size;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_done;
    logic [31:0]   rdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [1:0]    mem_stage_state;
    logic [31:0]   mem_read;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .LEN(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .if_req          (if_req),
        .if_addr         (if_addr),
        .if_done         (if_done),
        .d_req           (d_req),
        .d_we            (d_we),
        .d_size          (d_size),
        .d_addr          (d_addr),
        .d_wdata         (d_wdata),
        .d_done          (d_done),
        .rdata           (rdata),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_stage_state (mem_stage_state),
        .mem_read        (mem_read)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Initial memory image; word 0x100 holds 0x8899AABB little-endian.
    function automatic logic [7:0] init_byte(input int a);
        case (a)
            32'h100: return 8'hBB;
            32'h101: return 8'hAA;
            32'h102: return 8'h99;
            32'h103: return 8'h88;
            default: return 8'((a * 37 + 11) ^ (a >> 5));
        endcase
    endfunction

    // Memory seen by the DUT: READ returns addr..addr+3 on the next cycle.
    bit [7:0] mem    [0:MASK];
    bit       wr_vld [0:MASK];

    function automatic logic [7:0] mem_rd(input int a);
        int i;
        i = a & MASK;
        return wr_vld[i] ? mem[i] : init_byte(i);
    endfunction

    always @(posedge clk) begin
        if (mem_stage_state == C_WRITE) begin
            for (int i = 0; i < 4; i++) begin
                mem[(int'(mem_addr) + i) & MASK]    <= mem_wdata[8*i +: 8];
                wr_vld[(int'(mem_addr) + i) & MASK] <= 1'b1;
            end
        end
        if (mem_stage_state == C_READ) begin
            mem_read <= {mem_rd(int'(mem_addr) + 3), mem_rd(int'(mem_addr) + 2),
                         mem_rd(int'(mem_addr) + 1), mem_rd(int'(mem_addr))};
        end
    end

    // Reference model: byte-level memory image, last read value, last grant.
    logic [7:0]  ref_mem [int];
    logic [31:0] exp_rdata;
    bit          last_d;

    function automatic logic [7:0] ref_rd(input int a);
        int i;
        i = a & MASK;
        return ref_mem.exists(i) ? ref_mem[i] : init_byte(i);
    endfunction

    function automatic int size_bytes(input logic [2:0] sz);
        return (sz[1:0] == 2'b00) ? 1 : (sz[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] sz, input int a);
        longint v;
        int n;
        n = size_bytes(sz);
        v = 0;
        for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(ref_rd(a + i));
        if (n < 4 && !sz[2] && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
        return 32'(v);
    endfunction

    task automatic ref_store(input logic [2:0] sz, input int a, input logic [31:0] wd);
        for (int i = 0; i < size_bytes(sz); i++) ref_mem[(a + i) & MASK] = 8'(wd >> (8*i));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_if_done"}, 64'(if_done), 0);
        check_eq({tag, "_d_done"}, 64'(d_done), 0);
        check_eq({tag, "_rdata"}, 64'(rdata), 0);
        check_eq({tag, "_mem_addr"}, 64'(mem_addr), 0);
        check_eq({tag, "_mem_wdata"}, 64'(mem_wdata), 0);
        check_eq({tag, "_cmd"}, 64'(mem_stage_state), 64'(C_IDLE));
    endtask

    // One transaction from a single requester; inputs are scrambled after
    // the sampling edge to confirm they were latched.
    task automatic do_txn(input bit is_d, input bit we, input logic [2:0] sz,
                          input logic [AW-1:0] a, input logic [31:0] wd);
        int          lat;
        bit          is_wr;
        bit          word;
        bit          seen;
        logic [1:0]  ecmd;
        logic [31:0] exp_rd;
        is_wr = is_d && we;
        word  = (size_bytes(sz) == 4);
        lat   = !is_wr ? 3 : (word ? 2 : 4);
        exp_rd = is_wr ? exp_rdata : ref_load(is_d ? sz : 3'b010, int'(a));
        if (is_wr) ref_store(sz, int'(a), wd);
        @(negedge clk);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        @(posedge clk);
        seen = 1'b0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if_addr = AW'($urandom); d_addr = AW'($urandom); d_wdata = $urandom;
                d_size = 3'($urandom_range(0, 7)); d_we = 1'($urandom_range(0, 1));
            end
            ecmd = C_IDLE;
            if (k == 1) ecmd = (is_wr && word) ? C_WRITE : C_READ;
            if (is_wr && !word && k == 3) ecmd = C_WRITE;
            check_eq("cmd", 64'(mem_stage_state), 64'(ecmd));
            check_eq("mem_addr", 64'(mem_addr), 64'(a));
            if (if_done || d_done) begin
                seen = 1'b1;
                check_eq("done_cycle", 64'(k), 64'(lat));
                check_eq("done_who", 64'({if_done, d_done}), is_d ? 64'(2'b01) : 64'(2'b10));
                check_eq("rdata", 64'(rdata), 64'(exp_rd));
                if (is_wr) begin
                    for (int i = 0; i < 4; i++)
                        check_eq("store_mem", 64'(mem_rd(int'(a) + i)), 64'(ref_rd(int'(a) + i)));
                end
            end
        end
        if (!seen) check_eq("done_timeout", 0, 1);
        if_req = 1'b0;
        d_req  = 1'b0;
        exp_rdata = exp_rd;
        last_d    = is_d;
    endtask

    // Both requesters held; grants follow the tie rule from the model.
    task automatic arb_run(input int n);
        int          got;
        int          cyc;
        bit          g_d;
        logic [31:0] ev;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (if_done || d_done) begin
                g_d = !last_d;
                check_eq("arb_who", 64'({if_done, d_done}), g_d ? 64'(2'b01) : 64'(2'b10));
                ev = g_d ? ref_load(d_size, int'(d_addr)) : ref_load(3'b010, int'(if_addr));
                check_eq("arb_rdata", 64'(rdata), 64'(ev));
                last_d    = g_d;
                exp_rdata = ev;
                got++;
            end
        end
        check_eq("arb_count", 64'(got), 64'(n));
        if_req = 1'b0;
        d_req  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nw;
        int          nd;
        bit          r_d;
        bit          r_we;
        logic [2:0]  r_sz;
        logic [AW-1:0] r_a;

        rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_size = 3'b000;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        exp_rdata = '0; last_d = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        rst = 1'b0;

        // Directed: fetch, signed byte, zero-extended half, byte store, word load.
        do_txn(1'b0, 1'b0, 3'b010, AW'('h100), 32'h0);
        check_eq("fetch_0x100", 64'(rdata), 64'h8899AABB);
        do_txn(1'b1, 1'b0, 3'b000, AW'('h103), 32'h0);
        check_eq("lb_0x103", 64'(rdata), 64'hFFFFFF88);
        do_txn(1'b1, 1'b0, 3'b101, AW'('h102), 32'h0);
        check_eq("lhu_0x102", 64'(rdata), 64'h00008899);
        do_txn(1'b1, 1'b1, 3'b000, AW'('h101), 32'hDEADBE5A);
        do_txn(1'b1, 1'b0, 3'b010, AW'('h100), 32'h0);
        check_eq("lw_after_sb", 64'(rdata), 64'h88995ABB);

        // Arbitration with both requests held from reset.
        @(negedge clk);
        rst = 1'b1;
        if_addr = AW'('h100); d_addr = AW'('h102); d_size = 3'b001; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst1");
        exp_rdata = '0; last_d = 1'b0;
        rst = 1'b0;
        arb_run(4);

        // Randomized single-requester traffic.
        for (int t = 0; t < 40; t++) begin
            r_d  = 1'($urandom_range(0, 1));
            r_we = 1'($urandom_range(0, 1));
            r_sz = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       r_a = AW'(MASK - $urandom_range(0, 3));
                1:       r_a = AW'($urandom);
                default: r_a = AW'('h300 + $urandom_range(0, 12));
            endcase
            do_txn(r_d, r_we, r_sz, r_a, $urandom);
        end

        // Reset in RD_WAIT of a half store: nothing written, no done.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_size = 3'b001; d_addr = AW'('h200); d_wdata = $urandom;
        @(posedge clk);
        @(negedge clk);
        check_eq("rmw_c1_cmd", 64'(mem_stage_state), 64'(C_READ));
        @(negedge clk);
        check_eq("rmw_c2_cmd", 64'(mem_stage_state), 64'(C_IDLE));
        rst = 1'b1;
        d_req = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst2");
        rst = 1'b0;
        exp_rdata = '0; last_d = 1'b0;
        nw = 0;
        nd = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_stage_state == C_WRITE) nw++;
            if (d_done || if_done) nd++;
        end
        check_eq("rst_no_write", 64'(nw), 0);
        check_eq("rst_no_done", 64'(nd), 0);
        for (int i = 0; i < 4; i++)
            check_eq("rst_mem", 64'(mem_rd('h200 + i)), 64'(ref_rd('h200 + i)));

        // Last grant returns to fetch on reset, so data wins the first tie.
        @(negedge clk);
        if_addr = AW'('h104); d_addr = AW'('h300); d_size = 3'b010; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        arb_run(2);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
